// File: rtl/ccff_chain_loader.sv
// Loads a word-fed bitstream serially into a ccff chain, then recirculates it once and compares CRC-8 signatures.
// Latency: ceil(CHAIN_LEN/WORD_W) accept cycles + CHAIN_LEN shift cycles + CHAIN_LEN verify cycles + 1 done cycle.
// Backpressure: cfg_ready drops while a word is being shifted out; cfg_valid gaps only stall the chain.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 36,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done,
    output logic              cfg_ok,
    output logic              cfg_err
);
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [WORD_W-1:0] word_buf;
    logic              buf_full;
    logic [IDX_W-1:0]  bit_idx;
    logic [CNT_W-1:0]  bits_rem;
    logic [7:0]        crc;
    logic [7:0]        load_crc;
    logic [7:0]        crc_nx;
    logic              ok_q;
    logic              err_q;
    logic              accept;
    logic              shift_bit;
    logic              last_bit;

    // One serial step of CRC-8, polynomial x^8 + x^2 + x + 1.
    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    // State register.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) state <= IDLE;
        else            state <= state_nx;
    end

    // Next state, chain drive and handshake; the bit fed to the CRC is the bit driven onto the head.
    always_comb begin
        state_nx      = state;
        cfg_ready     = 1'b0;
        ccff_head     = 1'b0;
        ccff_shift_en = 1'b0;
        accept        = 1'b0;
        shift_bit     = 1'b0;
        last_bit      = (bits_rem == CNT_W'(1));
        busy          = (state != IDLE);
        done          = (state == DONE);
        case (state)
            IDLE: begin
                if (start) state_nx = LOAD;
            end
            LOAD: begin
                cfg_ready = !buf_full && (bits_rem != '0);
                accept    = cfg_ready && cfg_valid;
                if (buf_full) begin
                    ccff_shift_en = 1'b1;
                    shift_bit     = word_buf[bit_idx];
                    ccff_head     = shift_bit;
                    if (last_bit) state_nx = VERIFY;
                end
            end
            VERIFY: begin
                ccff_shift_en = 1'b1;
                shift_bit     = ccff_tail;
                ccff_head     = ccff_tail;
                if (last_bit) state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        crc_nx = crc8_step(crc, shift_bit);
    end

    // Word buffer, bit counters, CRC registers and sticky result flags.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            word_buf <= '0;
            buf_full <= 1'b0;
            bit_idx  <= '0;
            bits_rem <= '0;
            crc      <= 8'hFF;
            load_crc <= 8'hFF;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ok_q     <= 1'b0;
                        err_q    <= 1'b0;
                        bits_rem <= CNT_W'(CHAIN_LEN);
                        crc      <= 8'hFF;
                        buf_full <= 1'b0;
                        bit_idx  <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        word_buf <= cfg_data;
                        buf_full <= 1'b1;
                        bit_idx  <= '0;
                    end
                    if (buf_full) begin
                        crc      <= crc_nx;
                        bit_idx  <= bit_idx + 1'b1;
                        bits_rem <= bits_rem - 1'b1;
                        // Partial last word: upper bits are simply never shifted.
                        if (bit_idx == IDX_W'(WORD_W - 1) || last_bit) buf_full <= 1'b0;
                        if (last_bit) begin
                            load_crc <= crc_nx;
                            crc      <= 8'hFF;
                            bits_rem <= CNT_W'(CHAIN_LEN);
                        end
                    end
                end
                VERIFY: begin
                    crc      <= crc_nx;
                    bits_rem <= bits_rem - 1'b1;
                    if (last_bit) begin
                        if (crc_nx == load_crc) ok_q  <= 1'b1;
                        else                    err_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cfg_ok  = ok_q;
    assign cfg_err = err_q;
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: external chain modelled as shift registers, expected
// chain contents and timing derived from the word list and the sequence-length rules.
module tb_ccff_chain_loader;
    logic       prog_clk = 1'b0;
    logic       prog_reset;
    // default-parameter instance
    logic       start, cfg_valid, cfg_ready, ccff_head, ccff_tail, ccff_shift_en;
    logic       busy, done, cfg_ok, cfg_err;
    logic [7:0] cfg_data;
    // CHAIN_LEN=5, WORD_W=4 instance
    logic       s_start, s_cfg_valid, s_cfg_ready, s_ccff_head, s_ccff_tail, s_ccff_shift_en;
    logic       s_busy, s_done, s_cfg_ok, s_cfg_err;
    logic [3:0] s_cfg_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  words [5];
    int          gaps  [5];
    int          corrupt_idx = 0;
    logic        corrupt = 1'b0;
    logic [35:0] chain, chain_nx;
    logic [4:0]  chain5;

    always #5 prog_clk = ~prog_clk;

    ccff_chain_loader dut (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .ccff_head(ccff_head), .ccff_tail(ccff_tail), .ccff_shift_en(ccff_shift_en),
        .busy(busy), .done(done), .cfg_ok(cfg_ok), .cfg_err(cfg_err)
    );

    ccff_chain_loader #(.CHAIN_LEN(5), .WORD_W(4)) dut5 (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(s_start),
        .cfg_data(s_cfg_data), .cfg_valid(s_cfg_valid), .cfg_ready(s_cfg_ready),
        .ccff_head(s_ccff_head), .ccff_tail(s_ccff_tail), .ccff_shift_en(s_ccff_shift_en),
        .busy(s_busy), .done(s_done), .cfg_ok(s_cfg_ok), .cfg_err(s_cfg_err)
    );

    // Chain models: chain[0] is the head-end flop, the top bit feeds ccff_tail.
    always_comb begin
        chain_nx = chain;
        if (corrupt) chain_nx[corrupt_idx] = ~chain_nx[corrupt_idx];
        if (ccff_shift_en) chain_nx = {chain_nx[34:0], ccff_head};
    end
    always @(posedge prog_clk) begin
        chain <= chain_nx;
        if (s_ccff_shift_en) chain5 <= {chain5[3:0], s_ccff_head};
    end
    assign ccff_tail   = chain[35];
    assign s_ccff_tail = chain5[4];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full sequence on the default instance. cidx >= 0 flips that chain flop in the first VERIFY cycle.
    task automatic run_seq(input string tag, input int cidx, input bit busy_starts);
        logic [35:0] exp_chain;
        int   k, exp_done, wi, gap_left, nshift, stall_shift, done_at;
        logic ok_at_done, err_at_done, acc;
        exp_chain = '0;
        k = 0;
        exp_done = 1 + 36 + 1;          // start cycle offset, verify length, done cycle
        for (int w = 0; w < 5; w++) begin
            exp_done += gaps[w] + 1;
            for (int b = 0; b < 8; b++) begin
                if (k < 36) begin
                    exp_chain[35 - k] = words[w][b];
                    k++;
                    exp_done++;
                end
            end
        end
        exp_done = exp_done - 1;
        if (cidx >= 0) begin
            corrupt_idx = cidx;
            exp_chain[cidx] = ~exp_chain[cidx];
        end
        wi = 0; gap_left = gaps[0]; nshift = 0; stall_shift = 0; done_at = -1;
        ok_at_done = 1'b0; err_at_done = 1'b0;
        @(negedge prog_clk);
        for (int rel = 0; rel < 400 && done_at < 0; rel++) begin
            start   = (rel == 0) || (busy_starts && (rel == 5 || rel == 50));
            corrupt = (cidx >= 0) && (rel == exp_done - 36);
            acc = 1'b0;
            if (wi < 5 && cfg_ready) begin
                if (gap_left > 0) begin
                    cfg_valid = 1'b0;
                    gap_left--;
                end else begin
                    cfg_valid = 1'b1;
                    cfg_data  = words[wi];
                    acc = 1'b1;
                end
            end else begin
                cfg_valid = 1'($urandom_range(0, 1));
                cfg_data  = 8'($urandom);
            end
            #1;
            if (ccff_shift_en) nshift++;
            if (cfg_ready && ccff_shift_en) stall_shift++;
            if (done) begin
                done_at = rel;
                ok_at_done = cfg_ok;
                err_at_done = cfg_err;
            end
            @(negedge prog_clk);
            if (acc) begin
                wi++;
                if (wi < 5) gap_left = gaps[wi];
            end
        end
        start = 1'b0; corrupt = 1'b0; cfg_valid = 1'b0;
        check({tag, " done_cycle"}, 64'(done_at), 64'(exp_done));
        check({tag, " shift_cycles"}, 64'(nshift), 64'd72);
        check({tag, " shift_while_ready"}, 64'(stall_shift), 64'd0);
        check({tag, " cfg_ok"}, 64'(ok_at_done), 64'(cidx < 0));
        check({tag, " cfg_err"}, 64'(err_at_done), 64'(cidx >= 0));
        check({tag, " chain"}, 64'(chain), 64'(exp_chain));
        check({tag, " idle_after"}, {62'd0, busy, done}, 64'd0);
        check({tag, " flags_sticky"}, {62'd0, cfg_ok, cfg_err}, {62'd0, cidx < 0, cidx >= 0});
    endtask

    initial begin
        int done_at5;
        logic ok5, err5;
        prog_reset = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        s_start = 1'b0; s_cfg_valid = 1'b0; s_cfg_data = '0;
        repeat (3) @(negedge prog_clk);
        check("reset_outputs", {57'd0, cfg_ready, ccff_head, ccff_shift_en, busy, done, cfg_ok, cfg_err}, 64'd0);
        prog_reset = 1'b0;
        cfg_valid = 1'b1;
        @(negedge prog_clk);
        check("idle_ready_low", 64'(cfg_ready), 64'd0);
        cfg_valid = 1'b0;

        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF; words[3] = 8'h00; words[4] = 8'h09;
        for (int i = 0; i < 5; i++) gaps[i] = 0;
        run_seq("basic", -1, 1'b0);
        for (int i = 0; i < 5; i++) gaps[i] = 3;
        run_seq("gaps", -1, 1'b0);
        for (int i = 0; i < 5; i++) gaps[i] = 0;
        run_seq("corrupt", 20, 1'b0);
        run_seq("start_busy", -1, 1'b1);

        // Reset in the middle of the load.
        @(negedge prog_clk);
        start = 1'b1; cfg_valid = 1'b1; cfg_data = 8'($urandom);
        for (int r = 0; r < 20; r++) begin
            @(negedge prog_clk);
            start = 1'b0;
        end
        prog_reset = 1'b1;
        @(negedge prog_clk);
        check("midload_reset", {57'd0, cfg_ready, ccff_head, ccff_shift_en, busy, done, cfg_ok, cfg_err}, 64'd0);
        prog_reset = 1'b0; cfg_valid = 1'b0;
        run_seq("after_reset", -1, 1'b0);

        // Small instance: second word 0x1E contributes only its bit 0.
        done_at5 = -1; ok5 = 1'b0; err5 = 1'b0;
        begin
            int wi5;
            wi5 = 0;
            @(negedge prog_clk);
            for (int rel = 0; rel < 100 && done_at5 < 0; rel++) begin
                s_start = (rel == 0);
                s_cfg_valid = 1'b0;
                if (wi5 < 2 && s_cfg_ready) begin
                    s_cfg_valid = 1'b1;
                    s_cfg_data  = (wi5 == 0) ? 4'hF : 4'(8'h1E);
                end
                if (s_done) begin
                    done_at5 = rel; ok5 = s_cfg_ok; err5 = s_cfg_err;
                end
                @(negedge prog_clk);
                if (s_cfg_valid) wi5++;
            end
            s_start = 1'b0; s_cfg_valid = 1'b0;
        end
        check("small done_cycle", 64'(done_at5), 64'd13);
        check("small flags", {62'd0, ok5, err5}, 64'd2);
        check("small chain", 64'(chain5), 64'(5'b11110));

        // Randomized sequences.
        for (int n = 0; n < 4; n++) begin
            int ci;
            for (int i = 0; i < 5; i++) begin
                words[i] = 8'($urandom);
                gaps[i]  = int'($urandom_range(0, 3));
            end
            ci = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 34)) : -1;
            run_seq($sformatf("rand%0d", n), ci, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Configuration-chain loader and verifier for the routing tiles' configuration-flip-flop (ccff) chain. The block accepts a configuration bitstream as words over a valid/ready interface and serializes it onto the chain's `ccff_head`. It then recirculates the chain once, `ccff_tail` back into `ccff_head`, to check the loaded contents against a CRC taken during the load. It sits between the host-side bitstream source and the head of a chain of connection-block memories, which are four bits per mux.

## Interface
Parameters:
- `CHAIN_LEN`, default 36: total ccff bits in the driven chain (9 muxes × 4 bits); must be ≥ 1.
- `WORD_W`, default 8: configuration word width; must be ≥ 1.

Ports:
- `prog_clk`, in, 1: programming clock; all state is on its rising edge.
- `prog_reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: single-cycle request to begin a load; sampled only in IDLE.
- `cfg_data`, in, `WORD_W`: configuration word; bit 0 is shifted first.
- `cfg_valid`, in, 1: `cfg_data` is valid.
- `cfg_ready`, out, 1: the block accepts a word this cycle.
- `ccff_head`, out, 1: serial data into the chain.
- `ccff_tail`, in, 1: serial data out of the chain's last flop.
- `ccff_shift_en`, out, 1: chain clock enable. It goes to an external clock gate on `prog_clk`, so the chain shifts on an edge only where this is 1.
- `busy`, out, 1: not in IDLE.
- `done`, out, 1: one-cycle pulse at the end of a sequence.
- `cfg_ok`, out, 1: last verify passed. Sticky; cleared on accepted `start` or reset.
- `cfg_err`, out, 1: last verify failed. Sticky; cleared on accepted `start` or reset.

## Operation
- **States:** IDLE, LOAD, VERIFY, DONE.
- **IDLE → LOAD:** on `start`=1. This clears `cfg_ok`/`cfg_err`, loads the bit counter with `CHAIN_LEN`, initializes the CRC to 8'hFF and empties the word buffer.
- **LOAD, word intake:**
  - `cfg_ready` = (state==LOAD) && buffer empty && bits_remaining>0.
  - A word is accepted when `cfg_valid`&&`cfg_ready`. The buffer becomes full the next cycle with bit index 0.
- **LOAD, shifting:**
  - While the buffer is full: `ccff_shift_en`=1, `ccff_head`=buf[bit_idx].
  - CRC updates with that bit, bit_idx increments and bits_remaining decrements.
  - The buffer empties after bit `WORD_W`-1 or when bits_remaining reaches 0.
- **Last word:** the last word contributes only (`CHAIN_LEN` mod `WORD_W`) bits, or all `WORD_W` bits if the remainder is 0. Its unused upper bits are ignored.
- **Stall:** when the buffer is empty, `ccff_shift_en`=0 and `ccff_head`=0, and the chain holds. Any `cfg_valid` gaps only stall the load.
- **LOAD → VERIFY:** in the cycle after the final bit shifts. This reloads the counter with `CHAIN_LEN` and stores the load CRC in a second register, leaving the working CRC at 8'hFF.
- **VERIFY:**
  - Each cycle: `ccff_shift_en`=1, `ccff_head`=`ccff_tail` (recirculate), and the CRC updates with `ccff_tail`.
  - After `CHAIN_LEN` cycles the chain holds exactly its loaded contents. Tail bits emerge in load order.
- **VERIFY → DONE:** set `cfg_ok` if the verify CRC equals the load CRC, otherwise set `cfg_err`. DONE lasts one cycle (`done`=1), then returns to IDLE.
- **CRC:** CRC-8, polynomial 0x07. Per bit: fb=crc[7]^bit; crc={crc[6:0],1'b0}^(fb?8'h07:8'h00).
- **`start` while busy:** ignored; it has no effect on state or flags.
- **`cfg_valid` outside LOAD:** ignored, with `cfg_ready`=0.
- **Chain order:** the first bit shifted lands in the chain's far (tail-end) flop.

## Timing
- **Reset values:** state=IDLE, `cfg_ready`=0, `ccff_head`=0, `ccff_shift_en`=0, `busy`=0, `done`=0, `cfg_ok`=0, `cfg_err`=0.
- **Reset in any state:** takes effect on the next edge and aborts the sequence. Chain contents are then undefined, and the next `start` performs a full reload.
- **Combinational outputs:**
  - `ccff_head` and `ccff_shift_en` are combinational from state, buffer and `ccff_tail`.
  - `cfg_ready` is combinational from state and buffer only, never from `cfg_valid`.
- **Load throughput:** WORD_W bits per WORD_W+1 cycles, because there is a one-cycle accept bubble per word.
- **Total sequence length**, with `cfg_valid` tied high and `start` in cycle 0:
  - LOAD takes ceil(CHAIN_LEN/WORD_W) accept cycles plus CHAIN_LEN shift cycles.
  - VERIFY takes CHAIN_LEN cycles.
  - DONE takes 1 cycle.
- **Defaults (36, 8):**
  - LOAD in cycles 1–41: accepts in 1, 10, 19, 28, 37; the last word shifts in 38–41.
  - VERIFY in cycles 42–77.
  - `done` in cycle 78.
  - `busy` high in cycles 1–78.
  - Exactly 72 cycles have `ccff_shift_en`=1.

## Test plan
- **Basic load:** defaults, chain modelled as a 36-flop shift register. Words 0xA5, 0x3C, 0xFF, 0x00, 0x09 with valid tied high → `done` in cycle 78 and `cfg_ok`=1, `cfg_err`=0. The model chain reads, from the tail-end flop inward: bits 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1×8, 0×8, 1,0,0,1.
- **Valid gaps:** same words, with `cfg_valid` deasserted for 3 cycles before each word → the same chain contents and `cfg_ok`=1. `ccff_shift_en`=0 in every gap cycle, `done` is 15 cycles later (cycle 93), and the 72 shift-cycle total is unchanged.
- **Corrupted chain:** same stimulus, but the bench flips model flop 20 once during VERIFY before that bit reaches the tail → `cfg_err`=1, `cfg_ok`=0, `done` in cycle 78.
- **Start while busy:** `start` pulsed in cycles 5 and 50 → ignored. Exactly one `done`, in cycle 78, and the flags are unaffected.
- **Reset mid-load:** `prog_reset` in cycle 20 → next cycle has all outputs at their reset values and state IDLE. A fresh `start` then completes a full 78-cycle sequence with `cfg_ok`=1.
- **Non-default parameters:** `CHAIN_LEN`=5, `WORD_W`=4, words 0xF, 0x1E → the chain holds 1,1,1,1,0, where the second word's bits 1–3 are ignored. `cfg_ok`=1 and `done` in cycle 13.
